// File: rtl/m_fifo_flex_pkg.sv
// -----------------------------------------------------------------------------
// m_fifo_flex_pkg
//   Shared constants and helpers for the flexible FWFT FIFO:
//     - default WIDTH / AW / almost-level values
//     - fifo_depth(): DEPTH = 1 << AW
//     - clog2(): width of a counter holding 0..N-1
//   Optional feature macro used by this FIFO family: M_FIFO_FLEX_ALMOST_EN
// -----------------------------------------------------------------------------
`ifndef M_FIFO_FLEX_PKG_SV
`define M_FIFO_FLEX_PKG_SV

package m_fifo_flex_pkg;

    localparam int DEF_WIDTH  = 11;
    localparam int DEF_AW     = 4;
    localparam int DEF_AF_LVL = 2;
    localparam int DEF_AE_LVL = 2;

    // Number of entries addressed by an aw-bit pointer.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Bits needed to represent values 0..v-1 (ceil(log2(v))).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/m_fifo_flex_ram.sv
// -----------------------------------------------------------------------------
// m_fifo_flex_ram
//   WIDTH x DEPTH register array for m_fifo_flex. Not reset.
//   Ports:
//     clock  in   rising-edge clock
//     we     in   write enable
//     waddr  in   write address (AW bits)
//     wdata  in   write data (WIDTH bits)
//     raddr  in   read address (AW bits)
//     rdata  out  asynchronous read data, mem[raddr]
// -----------------------------------------------------------------------------
module m_fifo_flex_ram
    import m_fifo_flex_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(AW);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/m_fifo_flex.sv
// -----------------------------------------------------------------------------
// m_fifo_flex
//   Synchronous first-word-fall-through FIFO with src_rdy/dst_rdy handshake,
//   generic WIDTH and DEPTH = 2**AW, exporting free-space and occupancy counts.
//   Optional macro M_FIFO_FLEX_ALMOST_EN adds registered almost_full /
//   almost_empty outputs and their AF_LVL / AE_LVL parameters.
//   Ports:
//     clock         in   rising-edge clock
//     reset         in   asynchronous active-high reset
//     clear         in   synchronous flush, wins over same-cycle transfers
//     datain        in   write data
//     src_rdy_i     in   upstream has valid datain
//     dst_rdy_o     out  FIFO can accept (not full)
//     dataout       out  head-of-FIFO data, valid when src_rdy_o
//     src_rdy_o     out  FIFO not empty
//     dst_rdy_i     in   downstream accepts dataout
//     space         out  free entries 0..DEPTH
//     occupied      out  stored entries 0..DEPTH
//     almost_full   out  space <= AF_LVL     (macro only)
//     almost_empty  out  occupied <= AE_LVL  (macro only)
// -----------------------------------------------------------------------------
module m_fifo_flex
    import m_fifo_flex_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AW     = DEF_AW
`ifdef M_FIFO_FLEX_ALMOST_EN
    ,
    parameter int AF_LVL = DEF_AF_LVL,
    parameter int AE_LVL = DEF_AE_LVL
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] datain,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] dataout,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic [AW:0]      space,
    output logic [AW:0]      occupied
`ifdef M_FIFO_FLEX_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    localparam int DEPTH = fifo_depth(AW);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_nxt;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] ram_rdata;

    // Full/empty are taken from the occupancy counter only, so pointer
    // equality never has to be disambiguated.
    assign src_rdy_o = (occ != '0);
    assign dst_rdy_o = (occ != FULL_CNT);

    assign wr_en = src_rdy_i & dst_rdy_o;
    assign rd_en = src_rdy_o & dst_rdy_i;

    assign occupied = occ;
    assign space    = FULL_CNT - occ;

    always_comb begin
        occ_nxt = occ;
        case ({wr_en, rd_en})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            // AW-bit pointers wrap modulo DEPTH on their own.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ_nxt;
        end
    end

`ifdef M_FIFO_FLEX_ALMOST_EN
    // Computed from the next occupancy so the flags change on the same edge
    // as occupied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            almost_full  <= (DEPTH <= AF_LVL);
            almost_empty <= 1'b1;
        end else if (clear) begin
            almost_full  <= (DEPTH <= AF_LVL);
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (int'(FULL_CNT - occ_nxt) <= AF_LVL);
            almost_empty <= (int'(occ_nxt) <= AE_LVL);
        end
    end
`endif

    // A word dropped by clear must not land in the array.
    m_fifo_flex_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (wr_en & ~clear),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // The array is never reset; forcing zero while empty gives a defined
    // dataout after reset/clear instead of stale or unknown contents.
    assign dataout = src_rdy_o ? ram_rdata : '0;

endmodule

// File: tb/tb_m_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_m_fifo_flex
//   Self-checking bench for m_fifo_flex. Two instances share clock/reset/clear:
//   d0 (WIDTH=11, AW=4) and d1 (WIDTH=36, AW=1). Each is checked every cycle
//   against a queue-based reference model; directed sequences run on d0,
//   then both see random handshakes. Build with +define+M_FIFO_FLEX_ALMOST_EN
//   to include the almost flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_m_fifo_flex;

    localparam int DEP0 = 16;
    localparam int DEP1 = 2;
    localparam int AFL  = 2;
    localparam int AEL  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic clr;

    logic [10:0] din0, dout0;
    logic        sri0, dri0, sro0, dro0;
    logic [4:0]  space0, occ0;
    logic [35:0] din1, dout1;
    logic        sri1, dri1, sro1, dro1;
    logic [1:0]  space1, occ1;
`ifdef M_FIFO_FLEX_ALMOST_EN
    logic af0, ae0, af1, ae1;
`endif

    m_fifo_flex #(
        .WIDTH (11),
        .AW    (4)
`ifdef M_FIFO_FLEX_ALMOST_EN
        , .AF_LVL (AFL), .AE_LVL (AEL)
`endif
    ) d0 (
        .clock (clk), .reset (rst), .clear (clr),
        .datain (din0), .src_rdy_i (sri0), .dst_rdy_o (dro0),
        .dataout (dout0), .src_rdy_o (sro0), .dst_rdy_i (dri0),
        .space (space0), .occupied (occ0)
`ifdef M_FIFO_FLEX_ALMOST_EN
        , .almost_full (af0), .almost_empty (ae0)
`endif
    );

    m_fifo_flex #(
        .WIDTH (36),
        .AW    (1)
`ifdef M_FIFO_FLEX_ALMOST_EN
        , .AF_LVL (AFL), .AE_LVL (AEL)
`endif
    ) d1 (
        .clock (clk), .reset (rst), .clear (clr),
        .datain (din1), .src_rdy_i (sri1), .dst_rdy_o (dro1),
        .dataout (dout1), .src_rdy_o (sro1), .dst_rdy_i (dri1),
        .space (space1), .occupied (occ1)
`ifdef M_FIFO_FLEX_ALMOST_EN
        , .almost_full (af1), .almost_empty (ae1)
`endif
    );

    // Reference model: plain queues of stored words.
    logic [10:0] q0[$];
    logic [35:0] q1[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output of both instances with the model.
    task automatic check_all();
        chk("d0_occupied", 64'(occ0), 64'(q0.size()));
        chk("d0_space", 64'(space0), 64'(DEP0 - q0.size()));
        chk("d0_src_rdy_o", 64'(sro0), 64'(q0.size() != 0));
        chk("d0_dst_rdy_o", 64'(dro0), 64'(q0.size() != DEP0));
        if (q0.size() != 0) chk("d0_dataout", 64'(dout0), 64'(q0[0]));
        chk("d1_occupied", 64'(occ1), 64'(q1.size()));
        chk("d1_space", 64'(space1), 64'(DEP1 - q1.size()));
        chk("d1_src_rdy_o", 64'(sro1), 64'(q1.size() != 0));
        chk("d1_dst_rdy_o", 64'(dro1), 64'(q1.size() != DEP1));
        if (q1.size() != 0) chk("d1_dataout", 64'(dout1), 64'(q1[0]));
`ifdef M_FIFO_FLEX_ALMOST_EN
        chk("d0_almost_full", 64'(af0), 64'((DEP0 - q0.size()) <= AFL));
        chk("d0_almost_empty", 64'(ae0), 64'(q0.size() <= AEL));
        chk("d1_almost_full", 64'(af1), 64'((DEP1 - q1.size()) <= AFL));
        chk("d1_almost_empty", 64'(ae1), 64'(q1.size() <= AEL));
`endif
    endtask

    // Called at a falling edge with inputs already set: check, then apply
    // one rising edge to both the DUTs and the model.
    task automatic tick();
        bit w0, r0, w1, r1;
        check_all();
        w0 = sri0 && (q0.size() < DEP0);
        r0 = dri0 && (q0.size() > 0);
        w1 = sri1 && (q1.size() < DEP1);
        r1 = dri1 && (q1.size() > 0);
        @(posedge clk);
        if (clr) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0) void'(q0.pop_front());
            if (w0) q0.push_back(din0);
            if (r1) void'(q1.pop_front());
            if (w1) q1.push_back(din1);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sri0 = 1'b0; dri0 = 1'b0; din0 = '0;
        sri1 = 1'b0; dri1 = 1'b0; din1 = '0;
        clr  = 1'b0;
    endtask

    task automatic drain0();
        sri0 = 1'b0; dri0 = 1'b1;
        for (int i = 0; i < DEP0 + 2; i++) tick();
        dri0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        // Reset state
        check_all();
        chk("reset_dataout", 64'(dout0), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-stream: five words in, then async reset
        sri0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din0 = 11'(i + 'h50);
            tick();
        end
        sri0 = 1'b0;
        chk("mid_occ_before", 64'(occ0), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_occ", 64'(occ0), 64'd0);
        chk("async_space", 64'(space0), 64'd16);
        chk("async_src_rdy", 64'(sro0), 64'd0);
        chk("async_dst_rdy", 64'(dro0), 64'd1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fill to full, 17th word held off, drain in order
        sri0 = 1'b1; dri0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din0 = 11'(i);
            tick();
        end
        chk("full_dst_rdy", 64'(dro0), 64'd0);
        chk("full_occ", 64'(occ0), 64'd16);
        chk("full_space", 64'(space0), 64'd0);
        din0 = 11'h7FF;
        tick();
        chk("held_occ", 64'(occ0), 64'd16);
        sri0 = 1'b0; dri0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 64'(dout0), 64'(i));
            tick();
        end
        chk("drained_empty", 64'(sro0), 64'd0);
        dri0 = 1'b0;

        // Full plus read in the same cycle: no write at full
        sri0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din0 = 11'(i + 'h20);
            tick();
        end
        din0 = 11'h7FF; dri0 = 1'b1;
        tick();
        chk("full_rd_occ", 64'(occ0), 64'd15);
        chk("full_rd_dst_rdy", 64'(dro0), 64'd1);
        sri0 = 1'b0;
        drain0();

        // Streaming with wrap-around
        sri0 = 1'b1; dri0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din0 = 11'(i + 'h100);
            if (i > 0) begin
                chk("stream_occ", 64'(occ0), 64'd1);
                chk("stream_data", 64'(dout0), 64'(i - 1 + 'h100));
            end
            tick();
        end
        sri0 = 1'b0;
        drain0();

        // clear with write and read at occupied = 7
        sri0 = 1'b1; dri0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din0 = 11'(i + 'h200);
            tick();
        end
        din0 = 11'h3AB; dri0 = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_occ", 64'(occ0), 64'd0);
        chk("clear_src_rdy", 64'(sro0), 64'd0);
        sri0 = 1'b0; dri0 = 1'b0;
        tick();

`ifdef M_FIFO_FLEX_ALMOST_EN
        // almost_full rises at 14, falls back at 13
        sri0 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            din0 = 11'(i);
            tick();
        end
        chk("af_at_14", 64'(af0), 64'd1);
        chk("ae_at_14", 64'(ae0), 64'd0);
        sri0 = 1'b0; dri0 = 1'b1;
        tick();
        chk("af_at_13", 64'(af0), 64'd0);
        drain0();
        sri0 = 1'b1; dri0 = 1'b0;
        tick(); tick();
        chk("ae_at_2", 64'(ae0), 64'd1);
        tick();
        chk("ae_at_3", 64'(ae0), 64'd0);
        sri0 = 1'b0;
        drain0();
`endif

        // Random handshakes on both instances
        for (int i = 0; i < 3000; i++) begin
            sri0 = 1'($urandom_range(0, 1));
            dri0 = ($urandom_range(0, 3) != 0) ? (i % 512 < 256) : 1'b0;
            din0 = 11'($urandom);
            sri1 = 1'($urandom_range(0, 1));
            dri1 = 1'($urandom_range(0, 1));
            din1 = {4'($urandom), 32'($urandom)};
            clr  = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
